// File: rtl/fetch_prefetch_unit_if.sv
// Bundle of loader, redirect and decode-side signals for fetch_prefetch_unit.
// master is the fetch unit itself; slave is the surrounding loader/decode logic.
interface fetch_prefetch_unit_if #(
  parameter int ADDR_W   = 12,
  parameter int PF_DEPTH = 4
);
  localparam int CNT_W = $clog2(PF_DEPTH) + 1;

  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              fetch_en;
  logic              redir_vld;
  logic [1:0]        redir_sel;
  logic [31:0]       redir_reg;
  logic              dec_vld;
  logic              dec_rdy;
  logic [31:0]       dec_ir;
  logic [31:0]       dec_pc;
  logic [31:0]       dec_se;
  logic [CNT_W-1:0]  pf_cnt;
  logic              misalign_err;

  modport master (
    input  ld_we, ld_addr, ld_data, fetch_en, redir_vld, redir_sel, redir_reg, dec_rdy,
    output dec_vld, dec_ir, dec_pc, dec_se, pf_cnt, misalign_err
  );

  modport slave (
    output ld_we, ld_addr, ld_data, fetch_en, redir_vld, redir_sel, redir_reg, dec_rdy,
    input  dec_vld, dec_ir, dec_pc, dec_se, pf_cnt, misalign_err
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch unit: loader-writable big-endian word memory, prefetch queue, decode handshake.
// Optional macro MISALIGN_TRAP_EN sends misaligned redirect targets to TRAP_VEC with an error pulse.
module fetch_prefetch_unit #(
  parameter int          ADDR_W    = 12,
  parameter int          PF_DEPTH  = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0180
) (
  input logic                   clk,
  input logic                   reset,
  fetch_prefetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(PF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(PF_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t           state;
  logic [31:0]      mem [WORDS];
  logic [31:0]      q_ir [PF_DEPTH];
  logic [31:0]      q_pc [PF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic [31:0]      fetch_pc;
  logic [31:0]      rd_data;
  logic [31:0]      rd_pc;
  logic             inflight;
  logic [31:0]      last_ir;
  logic [31:0]      last_pc;
  logic             dec_vld;
  logic [31:0]      dec_ir;
  logic [31:0]      dec_pc;
  logic [31:0]      dec_se;
  logic [31:0]      pc_plus4;
  logic [31:0]      target;
  logic             redir_acc;
  logic             issue;
  logic             push;
  logic             pop;
  logic             unused_ok;

  assign dec_vld = (count != '0);
  assign dec_ir  = dec_vld ? q_ir[rd_ptr] : last_ir;
  assign dec_pc  = dec_vld ? q_pc[rd_ptr] : last_pc;
  assign dec_se  = {{16{dec_ir[15]}}, dec_ir[15:0]};

  assign bus.dec_vld = dec_vld;
  assign bus.dec_ir  = dec_ir;
  assign bus.dec_pc  = dec_pc;
  assign bus.dec_se  = dec_se;
  assign bus.pf_cnt  = count;

  assign unused_ok = ^{bus.ld_addr[1:0], TRAP_VEC};

  // Branch/jump targets come from the queue head; a head-relative redirect needs a valid head.
  always_comb begin
    pc_plus4  = dec_pc + 32'd4;
    target    = RESET_VEC;
    case (bus.redir_sel)
      2'b00:   target = pc_plus4 + {dec_se[29:0], 2'b00};
      2'b01:   target = {pc_plus4[31:28], dec_ir[25:0], 2'b00};
      2'b10:   target = bus.redir_reg;
      default: target = RESET_VEC;
    endcase
    redir_acc = bus.redir_vld && (bus.redir_sel[1] || dec_vld);
  end

  // In-flight reads count against queue space so a returning word always has a slot.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign issue     = bus.fetch_en && !bus.ld_we && !redir_acc && (occupancy < DEPTH_L);
  assign push      = inflight && (state != FLUSH);
  assign pop       = dec_vld && bus.dec_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (bus.ld_we) begin
      mem[bus.ld_addr[ADDR_W-1:2]] <= bus.ld_data;
    end else if (issue) begin
      rd_data <= mem[fetch_pc[ADDR_W-1:2]];
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  assign bus.misalign_err = misalign_q;
`else
  assign bus.misalign_err = 1'b0;
`endif

  // A redirect drops queued and in-flight words in the same edge it loads the new fetch PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_VEC;
      rd_pc    <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_ir  <= '0;
      last_pc  <= '0;
      for (int i = 0; i < PF_DEPTH; i++) begin
        q_ir[i] <= '0;
        q_pc[i] <= '0;
      end
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      if (dec_vld) begin
        last_ir <= dec_ir;
        last_pc <= dec_pc;
      end
      if (redir_acc) begin
        state    <= FLUSH;
        inflight <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
`ifdef MISALIGN_TRAP_EN
        if (target[1:0] != 2'b00) begin
          fetch_pc   <= TRAP_VEC;
          misalign_q <= 1'b1;
        end else begin
          fetch_pc <= target;
        end
`else
        fetch_pc <= target & 32'hFFFF_FFFC;
`endif
      end else begin
        state    <= bus.fetch_en ? FETCH : IDLE;
        inflight <= issue;
        if (issue) begin
          fetch_pc <= fetch_pc + 32'd4;
          rd_pc    <= fetch_pc;
        end
        if (push) begin
          q_ir[wr_ptr] <= rd_data;
          q_pc[wr_ptr] <= rd_pc;
          wr_ptr       <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: startup latency, back-pressure, redirects, wrap, loader.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_prefetch_unit;
  localparam int ADDR_W   = 12;
  localparam int PF_DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [31:0] exp_err;
  logic [31:0] exp_pc;
  logic [31:0] exp_ir;

  fetch_prefetch_unit_if #(.ADDR_W(ADDR_W), .PF_DEPTH(PF_DEPTH)) bus ();

  fetch_prefetch_unit #(
    .ADDR_W(ADDR_W),
    .PF_DEPTH(PF_DEPTH),
    .RESET_VEC(32'h0000_0000),
    .TRAP_VEC(32'h0000_0180)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [1:0] sel, input logic [31:0] regval);
    bus.redir_vld = vld;
    bus.redir_sel = sel;
    bus.redir_reg = regval;
  endtask

  task automatic loadWord(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    bus.ld_we   = 1'b1;
    bus.ld_addr = addr;
    bus.ld_data = data;
    tick();
    bus.ld_we = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.ld_we    = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    bus.fetch_en = 1'b0;
    bus.dec_rdy  = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'h0);
    tick();
    tick();
    checkOutput("rst_vld", 32'(bus.dec_vld), 32'd0);
    checkOutput("rst_cnt", 32'(bus.pf_cnt), 32'd0);
    checkOutput("rst_pc", bus.dec_pc, 32'd0);
    checkOutput("rst_ir", bus.dec_ir, 32'd0);
    checkOutput("rst_err", 32'(bus.misalign_err), 32'd0);

    reset = 1'b0;
    for (int i = 0; i < 16; i++) loadWord(ADDR_W'(i * 4), 32'hA000_0000 | 32'(i * 4));
    loadWord(12'h00C, 32'h1234_8765);
    loadWord(12'h010, 32'h1000_0003);
    loadWord(12'h014, 32'h0800_0040);
    loadWord(12'h040, 32'h2222_0040);
    loadWord(12'h100, 32'h1111_0100);
    loadWord(12'h180, 32'h3333_0180);
    loadWord(12'hFFC, 32'hAABB_CCFF);
    checkOutput("idle_vld", 32'(bus.dec_vld), 32'd0);

    // Memory survives reset; start fetching on release.
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    bus.fetch_en = 1'b1;
    bus.dec_rdy  = 1'b1;
    tick();
    checkOutput("lat_vld", 32'(bus.dec_vld), 32'd0);
    tick();
    checkOutput("first_vld", 32'(bus.dec_vld), 32'd1);
    checkOutput("first_pc", bus.dec_pc, 32'h0);
    checkOutput("first_ir", bus.dec_ir, 32'hA000_0000);
    tick();
    checkOutput("seq_pc4", bus.dec_pc, 32'h4);
    tick();
    checkOutput("seq_pc8", bus.dec_pc, 32'h8);
    tick();
    checkOutput("seq_pcC", bus.dec_pc, 32'hC);
    checkOutput("seq_irC", bus.dec_ir, 32'h1234_8765);
    checkOutput("seq_seC", bus.dec_se, 32'hFFFF_8765);

    bus.dec_rdy = 1'b0;
    repeat (10) tick();
    checkOutput("sat_cnt", 32'(bus.pf_cnt), 32'd4);
    checkOutput("sat_pc", bus.dec_pc, 32'hC);
    bus.dec_rdy = 1'b1;
    tick();
    checkOutput("rel_pc", bus.dec_pc, 32'h10);
    checkOutput("rel_ir", bus.dec_ir, 32'h1000_0003);

    applyStimulus(1'b1, 2'b00, 32'h0);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0);
    checkOutput("br_flush_vld", 32'(bus.dec_vld), 32'd0);
    checkOutput("br_flush_cnt", 32'(bus.pf_cnt), 32'd0);
    checkOutput("br_hold_pc", bus.dec_pc, 32'h10);
    tick();
    checkOutput("br_gap_vld", 32'(bus.dec_vld), 32'd0);
    tick();
    checkOutput("br_vld", 32'(bus.dec_vld), 32'd1);
    checkOutput("br_pc", bus.dec_pc, 32'h20);

    applyStimulus(1'b1, 2'b10, 32'h14);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0);
    tick();
    tick();
    checkOutput("reg14_pc", bus.dec_pc, 32'h14);
    checkOutput("reg14_ir", bus.dec_ir, 32'h0800_0040);

    applyStimulus(1'b1, 2'b01, 32'h0);
    tick();
    checkOutput("jmp_flush_vld", 32'(bus.dec_vld), 32'd0);
    applyStimulus(1'b1, 2'b00, 32'h0);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0);
    checkOutput("ign_vld", 32'(bus.dec_vld), 32'd0);
    tick();
    checkOutput("jmp_pc", bus.dec_pc, 32'h100);
    checkOutput("jmp_ir", bus.dec_ir, 32'h1111_0100);

    applyStimulus(1'b1, 2'b10, 32'hFFC);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0);
    tick();
    tick();
    checkOutput("wrap_pc0", bus.dec_pc, 32'hFFC);
    checkOutput("wrap_ir0", bus.dec_ir, 32'hAABB_CCFF);
    tick();
    checkOutput("wrap_pc1", bus.dec_pc, 32'h1000);
    checkOutput("wrap_ir1", bus.dec_ir, 32'hA000_0000);

`ifdef MISALIGN_TRAP_EN
    exp_err = 32'd1;
    exp_pc  = 32'h180;
    exp_ir  = 32'h3333_0180;
`else
    exp_err = 32'd0;
    exp_pc  = 32'h40;
    exp_ir  = 32'h2222_0040;
`endif
    applyStimulus(1'b1, 2'b10, 32'h42);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0);
    checkOutput("mis_err", 32'(bus.misalign_err), exp_err);
    tick();
    checkOutput("mis_err_end", 32'(bus.misalign_err), 32'd0);
    tick();
    checkOutput("mis_pc", bus.dec_pc, exp_pc);
    checkOutput("mis_ir", bus.dec_ir, exp_ir);

    // Loader holds the memory port for three cycles while fetch is running.
    bus.ld_we   = 1'b1;
    bus.ld_addr = 12'h200;
    bus.ld_data = 32'hDEAD_BEEF;
    tick();
    checkOutput("ld_head_pc", bus.dec_pc, exp_pc + 32'd4);
    bus.ld_addr = 12'h206;
    bus.ld_data = 32'hCAFE_F00D;
    tick();
    checkOutput("ld_stall_vld1", 32'(bus.dec_vld), 32'd0);
    bus.ld_addr = 12'h208;
    bus.ld_data = 32'h0BAD_F00D;
    tick();
    bus.ld_we = 1'b0;
    checkOutput("ld_stall_vld2", 32'(bus.dec_vld), 32'd0);
    tick();
    checkOutput("ld_stall_vld3", 32'(bus.dec_vld), 32'd0);
    tick();
    checkOutput("ld_resume_pc", bus.dec_pc, exp_pc + 32'd8);

    applyStimulus(1'b1, 2'b10, 32'h200);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0);
    tick();
    tick();
    checkOutput("ld_rb_ir0", bus.dec_ir, 32'hDEAD_BEEF);
    checkOutput("ld_rb_byte0", 32'(bus.dec_ir[31:24]), 32'hDE);
    tick();
    checkOutput("ld_rb_pc1", bus.dec_pc, 32'h204);
    checkOutput("ld_rb_ir1", bus.dec_ir, 32'hCAFE_F00D);

    applyStimulus(1'b1, 2'b11, 32'h300);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0);
    tick();
    tick();
    checkOutput("rv_pc", bus.dec_pc, 32'h0);
    checkOutput("rv_ir", bus.dec_ir, 32'hA000_0000);

    // Reset arrives together with a load write, which must be dropped.
    bus.ld_we   = 1'b1;
    bus.ld_addr = 12'h208;
    bus.ld_data = 32'hFFFF_FFFF;
    reset       = 1'b1;
    #1;
    checkOutput("async_rst_vld", 32'(bus.dec_vld), 32'd0);
    checkOutput("async_rst_cnt", 32'(bus.pf_cnt), 32'd0);
    tick();
    bus.ld_we = 1'b0;
    reset     = 1'b0;
    tick();
    tick();
    checkOutput("rst2_vld", 32'(bus.dec_vld), 32'd1);
    checkOutput("rst2_pc", bus.dec_pc, 32'h0);
    applyStimulus(1'b1, 2'b10, 32'h208);
    tick();
    applyStimulus(1'b0, 2'b00, 32'h0);
    tick();
    tick();
    checkOutput("rst_drop_ld", bus.dec_ir, 32'h0BAD_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
